// File: rtl/msx_mouse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msx_mouse_pkg
// Brief    : Shared types, constants and saturation helper for the MSX mouse.
// Revision : 1.0
// ============================================================================
package msx_mouse_pkg;

    typedef enum logic [1:0] {
        S_XH = 2'd0,
        S_XL = 2'd1,
        S_YH = 2'd2,
        S_YL = 2'd3
    } state_t;

    localparam int C_TIMEOUT_CYCLES = 100000;

    // Clamp a 10-bit signed sum into the signed 8-bit range the MSX reads.
    function automatic logic signed [7:0] sat8(input logic signed [9:0] value);
        if (value > 10'sh07F) begin
            return 8'sh7F;
        end else if (value < 10'sh380) begin
            return 8'sh80;
        end else begin
            return value[7:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/msx_mouse_acc.sv
`default_nettype none
// ============================================================================
// Module   : msx_mouse_acc
// Brief    : Saturating signed 8-bit accumulator of 9-bit mouse deltas.
// Revision : 1.0
// ============================================================================
module msx_mouse_acc
    import msx_mouse_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic       i_negate,
    input  logic [8:0] i_delta,
    output logic [7:0] o_acc
);

    logic signed [7:0] r_acc;
    logic signed [9:0] w_delta;
    logic signed [9:0] w_base;
    logic signed [9:0] w_sum;
    logic signed [7:0] w_acc_next;

    // A load coinciding with a clear lands in the freshly cleared value.
    always_comb begin
        w_delta    = i_negate ? -{i_delta[8], i_delta} : {i_delta[8], i_delta};
        w_base     = i_clear ? 10'sd0 : {{2{r_acc[7]}}, r_acc};
        w_sum      = w_base + w_delta;
        w_acc_next = r_acc;
        if (i_load) begin
            w_acc_next = sat8(w_sum);
        end else if (i_clear) begin
            w_acc_next = 8'sd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 8'sd0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/msx_mouse_port.sv
`default_nettype none
// ============================================================================
// Module   : msx_mouse_port
// Brief    : MSX mouse protocol: accumulates deltas, serves X/Y nibbles on
//            each toggle of the MSX strobe pin.
// Revision : 1.0
// ============================================================================
module msx_mouse_port #(
    parameter int TIMEOUT_CYCLES = msx_mouse_pkg::C_TIMEOUT_CYCLES
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic [7:0] mouse_flags,
    input  logic       mouse_strobe,
    input  logic       joy_active,
    input  logic       msx_str,
    output logic [5:0] port_out,
    output logic       mouse_en
);
    import msx_mouse_pkg::*;

    localparam int              C_TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_TW-1:0] C_TIMEOUT_LOAD = C_TW'(TIMEOUT_CYCLES);
    localparam logic [C_TW-1:0] C_TIMEOUT_ONE  = C_TW'(1);

    state_t          r_state;
    state_t          w_state_next;
    logic [C_TW-1:0] r_timeout;
    logic [C_TW-1:0] w_timeout_next;
    logic            r_str_d;
    logic            r_mouse_en;
    logic            w_mouse_en_next;
    logic [7:0]      r_snap_x;
    logic [7:0]      r_snap_y;
    logic [5:0]      r_port_out;
    logic [3:0]      w_nibble_next;
    logic            w_edge;
    logic            w_snap;
    logic            w_acc_clear;
    logic [7:0]      w_acc_x;
    logic [7:0]      w_acc_y;
    logic            w_unused_flags;

    assign w_unused_flags = ^mouse_flags[7:2];

    assign w_edge      = r_mouse_en & (msx_str ^ r_str_d);
    assign w_snap      = w_edge & (r_state == S_XH);
    assign w_acc_clear = w_snap | ~r_mouse_en;

    // X is negated so that the MSX sees left-positive motion.
    msx_mouse_acc u_acc_x (
        .clk      (clk_sys),
        .rst      (reset),
        .i_clear  (w_acc_clear),
        .i_load   (mouse_strobe),
        .i_negate (1'b1),
        .i_delta  (mouse_x),
        .o_acc    (w_acc_x)
    );

    msx_mouse_acc u_acc_y (
        .clk      (clk_sys),
        .rst      (reset),
        .i_clear  (w_acc_clear),
        .i_load   (mouse_strobe),
        .i_negate (1'b0),
        .i_delta  (mouse_y),
        .o_acc    (w_acc_y)
    );

    always_comb begin
        w_mouse_en_next = r_mouse_en;
        if (mouse_strobe) begin
            w_mouse_en_next = 1'b1;
        end else if (joy_active) begin
            w_mouse_en_next = 1'b0;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_timeout_next = r_timeout;
        w_nibble_next  = r_port_out[3:0];
        if (!r_mouse_en) begin
            w_state_next   = S_XH;
            w_timeout_next = '0;
        end else if (w_edge) begin
            w_timeout_next = C_TIMEOUT_LOAD;
            case (r_state)
                S_XH: begin
                    w_state_next  = S_XL;
                    w_nibble_next = w_acc_x[7:4];
                end
                S_XL: begin
                    w_state_next  = S_YH;
                    w_nibble_next = r_snap_x[3:0];
                end
                S_YH: begin
                    w_state_next  = S_YL;
                    w_nibble_next = r_snap_y[7:4];
                end
                default: begin
                    w_state_next  = S_XH;
                    w_nibble_next = r_snap_y[3:0];
                end
            endcase
        end else if (r_timeout != '0) begin
            w_timeout_next = r_timeout - 1'b1;
            if (r_timeout == C_TIMEOUT_ONE) begin
                w_state_next = S_XH;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= S_XH;
            r_timeout <= '0;
        end else begin
            r_state   <= w_state_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Port is forced idle in the same cycle the mouse loses ownership.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_str_d    <= 1'b0;
            r_mouse_en <= 1'b0;
            r_snap_x   <= '0;
            r_snap_y   <= '0;
            r_port_out <= 6'h3F;
        end else begin
            r_str_d    <= msx_str;
            r_mouse_en <= w_mouse_en_next;
            if (w_snap) begin
                r_snap_x <= w_acc_x;
                r_snap_y <= w_acc_y;
            end
            if (!w_mouse_en_next) begin
                r_port_out <= 6'h3F;
            end else begin
                r_port_out <= {~mouse_flags[1:0], w_nibble_next};
            end
        end
    end

    assign port_out = r_port_out;
    assign mouse_en = r_mouse_en;

endmodule
`default_nettype wire
